// File: rtl/pe_cluster_seq.sv
// pe_cluster_seq: job sequencer for the 16-lane Quad_PE cluster (stream, align, wait valid, drain).
// Optional feature macro: PE_TIMEOUT_EN (bounded WAIT_VALID that ends the job with err_o).
module pe_cluster_seq #(
    parameter int ADDR_W      = 12,
    parameter int CNT_W       = 10,
    parameter int READ_LAT    = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  cfg_num_words_i,
    input  logic [15:0]       cfg_pe_mask_i,
    input  logic [ADDR_W-1:0] cfg_ifm_base_i,
    input  logic [ADDR_W-1:0] cfg_wgt_base_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              ifm_rd_en_o,
    output logic [ADDR_W-1:0] ifm_rd_addr_o,
    output logic              wgt_rd_en_o,
    output logic [ADDR_W-1:0] wgt_rd_addr_o,
    output logic [15:0]       pe_reset_o,
    output logic [15:0]       pe_finish_o,
    input  logic [15:0]       pe_valid_i,
    output logic              ofm_valid_o,
    output logic [3:0]        ofm_sel_o,
    input  logic              ofm_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_WAIT_VALID,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    num_words_q, num_words_d;
    logic [15:0]         mask_q, mask_d;
    logic [ADDR_W-1:0]   ifm_base_q, ifm_base_d;
    logic [ADDR_W-1:0]   wgt_base_q, wgt_base_d;
    logic                empty_q, empty_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   ifm_addr_q, ifm_addr_d;
    logic [ADDR_W-1:0]   wgt_addr_q, wgt_addr_d;
    logic                arrived_q, arrived_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [READ_LAT-1:0] dl_valid_q, dl_valid_d;
    logic [READ_LAT-1:0] dl_last_q, dl_last_d;

    logic       last_word;
    logic       arrive;
    logic       arrive_last;
    logic       all_valid;
    logic [3:0] drain_sel;

    assign last_word   = (idx_q == num_words_q - CNT_W'(1));
    assign arrive      = dl_valid_q[READ_LAT-1];
    assign arrive_last = arrive && dl_last_q[READ_LAT-1];
    assign all_valid   = ((pe_valid_i & mask_q) == mask_q);

    // Lowest lane still owed a handshake; remaining_q only changes on a handshake, so sel holds.
    always_comb begin
        drain_sel = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (remaining_q[i]) drain_sel = 4'(i);
        end
    end

`ifdef PE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_err_q, to_err_d;
    logic            timed_out;

    always_comb begin
        to_cnt_d  = (state_q == S_WAIT_VALID) ? to_cnt_q + TO_W'(1) : '0;
        timed_out = (state_q == S_WAIT_VALID) && !all_valid &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
        to_err_d  = to_err_q;
        if (timed_out) begin
            to_err_d = 1'b1;
        end else if (state_q == S_DONE) begin
            to_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign err_o = (state_q == S_DONE) && to_err_q;
`else
    logic timed_out;
    assign timed_out = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state value gets its hold default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        num_words_d = num_words_q;
        mask_d      = mask_q;
        ifm_base_d  = ifm_base_q;
        wgt_base_d  = wgt_base_q;
        empty_d     = empty_q;
        idx_d       = idx_q;
        ifm_addr_d  = ifm_addr_q;
        wgt_addr_d  = wgt_addr_q;
        arrived_d   = arrived_q || arrive;
        remaining_d = remaining_q;

        dl_valid_d[0] = (state_q == S_STREAM);
        dl_last_d[0]  = (state_q == S_STREAM) && last_word;
        for (int i = 1; i < READ_LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_last_d[i]  = dl_last_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    num_words_d = cfg_num_words_i;
                    mask_d      = cfg_pe_mask_i;
                    ifm_base_d  = cfg_ifm_base_i;
                    wgt_base_d  = cfg_wgt_base_i;
                    empty_d     = (cfg_num_words_i == '0) || (cfg_pe_mask_i == '0);
                    remaining_d = cfg_pe_mask_i;
                    arrived_d   = 1'b0;
                    state_d     = S_CLEAR;
                end
            end
            // Empty jobs pass through CLEAR with every strobe suppressed, so done lands on cycle 2.
            S_CLEAR: begin
                idx_d = '0;
                if (empty_q) begin
                    state_d = S_DONE;
                end else begin
                    ifm_addr_d = ifm_base_q;
                    wgt_addr_d = wgt_base_q;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_word) begin
                    state_d = S_FLUSH;
                end else begin
                    idx_d      = idx_q + CNT_W'(1);
                    ifm_addr_d = ifm_addr_q + ADDR_W'(1);
                    wgt_addr_d = wgt_addr_q + ADDR_W'(1);
                end
            end
            S_FLUSH: begin
                if (arrive_last) state_d = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (all_valid) begin
                    state_d = S_DRAIN;
                end else if (timed_out) begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (ofm_ready_i) begin
                    remaining_d = remaining_q & (remaining_q - 16'd1);
                    if ((remaining_q & (remaining_q - 16'd1)) == '0) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= S_IDLE;
            num_words_q <= '0;
            mask_q      <= '0;
            ifm_base_q  <= '0;
            wgt_base_q  <= '0;
            empty_q     <= 1'b0;
            idx_q       <= '0;
            ifm_addr_q  <= '0;
            wgt_addr_q  <= '0;
            arrived_q   <= 1'b0;
            remaining_q <= '0;
            // NOTE: the delay line is reset because its valid bits steer pe_finish after an aborted job.
            dl_valid_q  <= '0;
            dl_last_q   <= '0;
        end else begin
            state_q     <= state_d;
            num_words_q <= num_words_d;
            mask_q      <= mask_d;
            ifm_base_q  <= ifm_base_d;
            wgt_base_q  <= wgt_base_d;
            empty_q     <= empty_d;
            idx_q       <= idx_d;
            ifm_addr_q  <= ifm_addr_d;
            wgt_addr_q  <= wgt_addr_d;
            arrived_q   <= arrived_d;
            remaining_q <= remaining_d;
            dl_valid_q  <= dl_valid_d;
            dl_last_q   <= dl_last_d;
        end
    end

    always_comb begin
        busy_o        = (state_q != S_IDLE);
        done_o        = (state_q == S_DONE);
        ifm_rd_en_o   = (state_q == S_STREAM);
        wgt_rd_en_o   = (state_q == S_STREAM);
        ifm_rd_addr_o = ifm_addr_q;
        wgt_rd_addr_o = wgt_addr_q;
        pe_finish_o   = arrive_last ? mask_q : 16'h0000;
        ofm_valid_o   = (state_q == S_DRAIN);
        ofm_sel_o     = (state_q == S_DRAIN) ? drain_sel : 4'd0;
        pe_reset_o    = 16'h0000;
        // Accumulator clear spans CLEAR up to, but not including, the first word's arrival.
        if ((state_q == S_CLEAR && !empty_q) ||
            ((state_q == S_STREAM || state_q == S_FLUSH) && !arrived_q && !arrive)) begin
            pe_reset_o = mask_q;
        end
    end

endmodule

// File: tb/tb_pe_cluster_seq.sv
// tb_pe_cluster_seq: directed timeline checks for pe_cluster_seq (instance a: READ_LAT=1, b: READ_LAT=3).
// Define PE_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_pe_cluster_seq;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_a, start_b;
    logic [CNT_W-1:0]  num_words;
    logic [15:0]       pe_mask;
    logic [ADDR_W-1:0] ifm_base, wgt_base;
    logic [15:0]       pe_valid;
    logic              ofm_ready;

    logic              busy_a, done_a, err_a, ifm_en_a, wgt_en_a, ofm_valid_a;
    logic [ADDR_W-1:0] ifm_addr_a, wgt_addr_a;
    logic [15:0]       pe_reset_a, pe_finish_a;
    logic [3:0]        ofm_sel_a;

    logic              busy_b, done_b, err_b, ifm_en_b, wgt_en_b, ofm_valid_b;
    logic [ADDR_W-1:0] ifm_addr_b, wgt_addr_b;
    logic [15:0]       pe_reset_b, pe_finish_b;
    logic [3:0]        ofm_sel_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_cluster_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .READ_LAT(1), .TIMEOUT_CYC(8)) u_dut_a (
        .clk(clk), .reset(reset), .start_i(start_a),
        .cfg_num_words_i(num_words), .cfg_pe_mask_i(pe_mask),
        .cfg_ifm_base_i(ifm_base), .cfg_wgt_base_i(wgt_base),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
        .ifm_rd_en_o(ifm_en_a), .ifm_rd_addr_o(ifm_addr_a),
        .wgt_rd_en_o(wgt_en_a), .wgt_rd_addr_o(wgt_addr_a),
        .pe_reset_o(pe_reset_a), .pe_finish_o(pe_finish_a), .pe_valid_i(pe_valid),
        .ofm_valid_o(ofm_valid_a), .ofm_sel_o(ofm_sel_a), .ofm_ready_i(ofm_ready)
    );

    pe_cluster_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .READ_LAT(3), .TIMEOUT_CYC(8)) u_dut_b (
        .clk(clk), .reset(reset), .start_i(start_b),
        .cfg_num_words_i(num_words), .cfg_pe_mask_i(pe_mask),
        .cfg_ifm_base_i(ifm_base), .cfg_wgt_base_i(wgt_base),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
        .ifm_rd_en_o(ifm_en_b), .ifm_rd_addr_o(ifm_addr_b),
        .wgt_rd_en_o(wgt_en_b), .wgt_rd_addr_o(wgt_addr_b),
        .pe_reset_o(pe_reset_b), .pe_finish_o(pe_finish_b), .pe_valid_i(pe_valid),
        .ofm_valid_o(ofm_valid_b), .ofm_sel_o(ofm_sel_b), .ofm_ready_i(ofm_ready)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Supplies valid/ready until the chosen instance pulses done, bounded to 100 cycles.
    task automatic finish_job(input bit use_b, input string tag);
        bit seen;
        seen      = 1'b0;
        pe_valid  = 16'hFFFF;
        ofm_ready = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = use_b ? done_b : done_a;
        end
        check({tag, " done"}, 32'(seen), 32'd1);
        pe_valid = 16'h0000;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] exp_addr;
        reset     = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        num_words = '0;
        pe_mask   = '0;
        ifm_base  = '0;
        wgt_base  = '0;
        pe_valid  = '0;
        ofm_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst busy_a", 32'(busy_a), 32'd0);
        check("rst done_a", 32'(done_a), 32'd0);
        check("rst err_a", 32'(err_a), 32'd0);
        check("rst rd_en_a", 32'({ifm_en_a, wgt_en_a}), 32'd0);
        check("rst addr_a", 32'({ifm_addr_a, wgt_addr_a}), 32'd0);
        check("rst pe_a", 32'({pe_reset_a, pe_finish_a}), 32'd0);
        check("rst ofm_a", 32'({ofm_valid_a, ofm_sel_a}), 32'd0);
        check("rst busy_b", 32'(busy_b), 32'd0);
        reset = 1'b0;

        // Test 1: N=4, full mask, valid three cycles after finish, ready always high.
        @(negedge clk);
        start_a = 1'b1; num_words = 10'd4; pe_mask = 16'hFFFF;
        ifm_base = 12'h010; wgt_base = 12'h200;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            check($sformatf("t1 busy c%0d", k), 32'(busy_a), 32'(k <= 26));
            check($sformatf("t1 done c%0d", k), 32'(done_a), 32'(k == 26));
            check($sformatf("t1 ifm_en c%0d", k), 32'(ifm_en_a), 32'(k >= 2 && k <= 5));
            check($sformatf("t1 wgt_en c%0d", k), 32'(wgt_en_a), 32'(k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) begin
                check($sformatf("t1 ifm_addr c%0d", k), 32'(ifm_addr_a), 32'h010 + 32'(k - 2));
                check($sformatf("t1 wgt_addr c%0d", k), 32'(wgt_addr_a), 32'h200 + 32'(k - 2));
            end
            check($sformatf("t1 pe_reset c%0d", k), 32'(pe_reset_a), (k <= 2) ? 32'hFFFF : 32'h0);
            check($sformatf("t1 pe_finish c%0d", k), 32'(pe_finish_a), (k == 6) ? 32'hFFFF : 32'h0);
            check($sformatf("t1 ofm_valid c%0d", k), 32'(ofm_valid_a), 32'(k >= 10 && k <= 25));
            if (k >= 10 && k <= 25) check($sformatf("t1 ofm_sel c%0d", k), 32'(ofm_sel_a), 32'(k - 10));
            pe_valid = (k >= 9) ? 16'hFFFF : 16'h0000;
        end
        pe_valid = 16'h0000;

        // Test 2: sparse mask 0x8101, partial valid first, ready alternating.
        @(negedge clk);
        start_a = 1'b1; num_words = 10'd2; pe_mask = 16'h8101;
        ifm_base = 12'h040; wgt_base = 12'h300;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            check($sformatf("t2 pe_reset c%0d", k), 32'(pe_reset_a), (k <= 2) ? 32'h8101 : 32'h0);
            check($sformatf("t2 pe_finish c%0d", k), 32'(pe_finish_a), (k == 4) ? 32'h8101 : 32'h0);
            check($sformatf("t2 ofm_valid c%0d", k), 32'(ofm_valid_a), 32'(k >= 7 && k <= 11));
            if (k >= 7 && k <= 11)
                check($sformatf("t2 ofm_sel c%0d", k), 32'(ofm_sel_a), (k == 7) ? 32'd0 : (k <= 9) ? 32'd8 : 32'd15);
            check($sformatf("t2 done c%0d", k), 32'(done_a), 32'(k == 12));
            pe_valid  = (k == 5) ? 16'h0101 : (k >= 6) ? 16'h8103 : 16'h0000;
            ofm_ready = (k % 2 == 1);
        end
        pe_valid  = 16'h0000;
        ofm_ready = 1'b1;

        // Test 3: N=0 job, start held through CLEAR/DONE, then a mask=0 job back-to-back.
        @(negedge clk);
        start_a = 1'b1; num_words = 10'd0; pe_mask = 16'hFFFF;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            num_words = 10'd5; pe_mask = 16'h0000;
            check($sformatf("t3 done c%0d", k), 32'(done_a), 32'(k == 2 || k == 5));
            check($sformatf("t3 busy c%0d", k), 32'(busy_a), 32'(k == 1 || k == 2 || k == 4 || k == 5));
            check($sformatf("t3 rd_en c%0d", k), 32'({ifm_en_a, wgt_en_a}), 32'd0);
            check($sformatf("t3 pe c%0d", k), 32'({pe_reset_a, pe_finish_a}), 32'd0);
            start_a = (k <= 3);
        end

        // Test 4: READ_LAT=3, N=1.
        @(negedge clk);
        start_b = 1'b1; num_words = 10'd1; pe_mask = 16'hFFFF;
        ifm_base = 12'h123; wgt_base = 12'h456;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            check($sformatf("t4 pe_reset c%0d", k), 32'(pe_reset_b), (k <= 4) ? 32'hFFFF : 32'h0);
            check($sformatf("t4 rd_en c%0d", k), 32'(ifm_en_b), 32'(k == 2));
            if (k == 2) check("t4 ifm_addr", 32'(ifm_addr_b), 32'h123);
            check($sformatf("t4 pe_finish c%0d", k), 32'(pe_finish_b), (k == 5) ? 32'hFFFF : 32'h0);
        end
        finish_job(1'b1, "t4");

        // Test 5: reset during STREAM, then a fresh job whose addresses wrap.
        @(negedge clk);
        start_a = 1'b1; num_words = 10'd8; pe_mask = 16'hFFFF;
        ifm_base = 12'h020; wgt_base = 12'h100;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (k >= 2) check($sformatf("t5a addr c%0d", k), 32'(ifm_addr_a), 32'h020 + 32'(k - 2));
        end
        reset = 1'b1;
        @(negedge clk);
        check("t5 rst busy", 32'(busy_a), 32'd0);
        check("t5 rst done", 32'(done_a), 32'd0);
        check("t5 rst rd_en", 32'({ifm_en_a, wgt_en_a}), 32'd0);
        check("t5 rst addr", 32'({ifm_addr_a, wgt_addr_a}), 32'd0);
        check("t5 rst pe", 32'({pe_reset_a, pe_finish_a}), 32'd0);
        reset = 1'b0;
        start_a = 1'b1; num_words = 10'd3; ifm_base = 12'hFFE; wgt_base = 12'h100;
        for (int r = 1; r <= 8; r++) begin
            @(negedge clk);
            start_a = 1'b0;
            check($sformatf("t5 done r%0d", r), 32'(done_a), 32'd0);
            check($sformatf("t5 rd_en r%0d", r), 32'(ifm_en_a), 32'(r >= 2 && r <= 4));
            if (r >= 2 && r <= 4) begin
                exp_addr = 12'hFFE + 12'(r - 2);
                check($sformatf("t5 ifm_addr r%0d", r), 32'(ifm_addr_a), 32'(exp_addr));
                check($sformatf("t5 wgt_addr r%0d", r), 32'(wgt_addr_a), 32'h100 + 32'(r - 2));
            end
            check($sformatf("t5 pe_reset r%0d", r), 32'(pe_reset_a), (r <= 2) ? 32'hFFFF : 32'h0);
            check($sformatf("t5 pe_finish r%0d", r), 32'(pe_finish_a), (r == 5) ? 32'hFFFF : 32'h0);
        end
        finish_job(1'b0, "t5");

        // Test 6: pe_valid stuck low.
        @(negedge clk);
        start_a = 1'b1; num_words = 10'd1; pe_mask = 16'hFFFF; pe_valid = 16'h0000;
`ifdef PE_TIMEOUT_EN
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            check($sformatf("t6 done c%0d", k), 32'(done_a), 32'(k == 12));
            check($sformatf("t6 err c%0d", k), 32'(err_a), 32'(k == 12));
            check($sformatf("t6 busy c%0d", k), 32'(busy_a), 32'(k <= 12));
            check($sformatf("t6 ofm_valid c%0d", k), 32'(ofm_valid_a), 32'd0);
        end
`else
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            check($sformatf("t6 busy c%0d", k), 32'(busy_a), 32'd1);
            check($sformatf("t6 done c%0d", k), 32'(done_a), 32'd0);
            check($sformatf("t6 err c%0d", k), 32'(err_a), 32'd0);
            check($sformatf("t6 ofm_valid c%0d", k), 32'(ofm_valid_a), 32'd0);
        end
        finish_job(1'b0, "t6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
